// File: rtl/watch_pkg.sv
// Shared BCD calendar definitions for the watch datapath.
// Provides field reset values, field limits, the packed load layout and
// the BCD helpers (digit validity, leap year, month length). The setting
// stage imports the same package for its cursor limits.
package watch_pkg;

    localparam int unsigned BCD_W  = 8;
    localparam int unsigned TIME_W = 6 * BCD_W;

    typedef logic [BCD_W-1:0] bcd_t;

    // Packed load/compare layout: yy in the top byte, ss in the bottom byte.
    typedef struct packed {
        bcd_t yy;
        bcd_t mm;
        bcd_t dd;
        bcd_t hh;
        bcd_t mi;
        bcd_t ss;
    } cal_time_t;

    // Reset values (calendar starts at 2000-01-01 00:00:00).
    localparam bcd_t YEAR_RST   = 8'h00;
    localparam bcd_t MONTH_RST  = 8'h01;
    localparam bcd_t DAY_RST    = 8'h01;
    localparam bcd_t HOUR_RST   = 8'h00;
    localparam bcd_t MINUTE_RST = 8'h00;
    localparam bcd_t SECOND_RST = 8'h00;

    // Field limits.
    localparam bcd_t SECOND_MAX = 8'h59;
    localparam bcd_t MINUTE_MAX = 8'h59;
    localparam bcd_t HOUR_MAX   = 8'h23;
    localparam bcd_t MONTH_MAX  = 8'h12;
    localparam bcd_t YEAR_MAX   = 8'h99;
    localparam bcd_t FIELD_ZERO = 8'h00;
    localparam bcd_t FIELD_ONE  = 8'h01;

    // Both digits in 0..9.
    function automatic logic bcd_valid(input bcd_t v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // yy mod 4 == 0 without a binary conversion: 10 mod 4 == 2, so
    // yy mod 4 == (2*tens + ones) mod 4, and only tens[0] matters.
    function automatic logic is_leap(input bcd_t yy);
        logic [1:0] r;
        r = yy[1:0] + {yy[4], 1'b0};
        return (r == 2'd0);
    endfunction

    // Month length in BCD for a given yy/mm.
    function automatic bcd_t days_in_month(input bcd_t yy, input bcd_t mm);
        bcd_t d;
        d = 8'h31;
        case (mm)
            8'h04, 8'h06, 8'h09, 8'h11: d = 8'h30;
            8'h02:                      d = is_leap(yy) ? 8'h29 : 8'h28;
            default:                    d = 8'h31;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/watch_bcd_field.sv
// One BCD calendar field: 8-bit register with load, increment and wrap.
// Ports:
//   clk, rst      clock, async active-low reset (to RST_VAL)
//   inc           advance this field by one
//   load          take load_val (wins over inc)
//   load_val      value to load
//   min, max      wrap range; at max an increment returns to min
//   value         current registered field value
//   carry         inc while at max, feeds the next field up
module watch_bcd_field
    import watch_pkg::*;
#(
    parameter bcd_t RST_VAL = 8'h00
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic load,
    input  bcd_t load_val,
    input  bcd_t min,
    input  bcd_t max,
    output bcd_t value,
    output logic carry
);

    bcd_t value_q;
    bcd_t value_d;

    // Next value: load, else BCD increment with wrap at max.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (inc) begin
            if (value_q == max) begin
                value_d = min;
            end else if (value_q[3:0] == 4'd9) begin
                value_d = {value_q[7:4] + 4'd1, 4'd0};
            end else begin
                value_d = {value_q[7:4], value_q[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= RST_VAL;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign carry = inc && (value_q == max);

endmodule

// File: rtl/watch_counter.sv
// Real-time clock/calendar core (2000-2099, leap-year aware).
// Divides clk to a 1 Hz advance, runs a single-edge BCD cascade and
// accepts validated full time/date loads from the setting stage.
// Ports:
//   clk, rst       clock, async active-low reset
//   run            count enable for prescaler and calendar
//   en_time        load strobe; bin_time packed yy,mm,dd,hh,mi,ss (BCD)
//   year..second   registered BCD calendar fields
//   tick           one-cycle pulse in the first cycle of a new second
//   load_err       one-cycle pulse when a load is rejected
module watch_counter
    import watch_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              en_time,
    input  logic [TIME_W-1:0] bin_time,
    output logic [BCD_W-1:0]  year,
    output logic [BCD_W-1:0]  month,
    output logic [BCD_W-1:0]  day,
    output logic [BCD_W-1:0]  hour,
    output logic [BCD_W-1:0]  minute,
    output logic [BCD_W-1:0]  second,
    output logic              tick,
    output logic              load_err
);

    localparam int unsigned        PRESC_W  = $clog2(CLK_HZ);
    localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(CLK_HZ - 1);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic               tick_q;
    logic               load_err_q;

    cal_time_t ld;
    logic      load_valid_c;
    logic      at_tc_c;
    logic      load_ok_c;
    logic      load_bad_c;
    logic      advance_c;
    logic      count_c;
    bcd_t      day_max_c;

    logic carry_ss;
    logic carry_mi;
    logic carry_hh;
    logic carry_dd;
    logic carry_mm;
    logic unused_carry_yy;

    assign ld = cal_time_t'(bin_time);

    // Accept only well-formed BCD within every field range, day checked
    // against the length of the month being loaded.
    always_comb begin
        load_valid_c = bcd_valid(ld.yy) && bcd_valid(ld.mm) && bcd_valid(ld.dd) &&
                       bcd_valid(ld.hh) && bcd_valid(ld.mi) && bcd_valid(ld.ss) &&
                       (ld.mm >= FIELD_ONE) && (ld.mm <= MONTH_MAX) &&
                       (ld.dd >= FIELD_ONE) && (ld.dd <= days_in_month(ld.yy, ld.mm)) &&
                       (ld.hh <= HOUR_MAX) && (ld.mi <= MINUTE_MAX) &&
                       (ld.ss <= SECOND_MAX);
    end

    // Any load (good or bad) blocks counting in that cycle.
    assign at_tc_c    = (presc_q == PRESC_TC);
    assign load_ok_c  = en_time && load_valid_c;
    assign load_bad_c = en_time && !load_valid_c;
    assign count_c    = run && !en_time;
    assign advance_c  = count_c && at_tc_c;

    always_comb begin
        presc_d = presc_q;
        if (load_ok_c) begin
            presc_d = '0;
        end else if (count_c) begin
            presc_d = at_tc_c ? '0 : presc_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q    <= '0;
            tick_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            tick_q     <= advance_c;
            load_err_q <= load_bad_c;
        end
    end

    assign tick     = tick_q;
    assign load_err = load_err_q;

    // Day wraps at the length of the current month/year.
    assign day_max_c = days_in_month(year, month);

    // Carry chain is combinational so the whole cascade lands on one edge.
    watch_bcd_field #(.RST_VAL(SECOND_RST)) u_second (
        .clk      (clk),
        .rst      (rst),
        .inc      (advance_c),
        .load     (load_ok_c),
        .load_val (ld.ss),
        .min      (FIELD_ZERO),
        .max      (SECOND_MAX),
        .value    (second),
        .carry    (carry_ss)
    );

    watch_bcd_field #(.RST_VAL(MINUTE_RST)) u_minute (
        .clk      (clk),
        .rst      (rst),
        .inc      (carry_ss),
        .load     (load_ok_c),
        .load_val (ld.mi),
        .min      (FIELD_ZERO),
        .max      (MINUTE_MAX),
        .value    (minute),
        .carry    (carry_mi)
    );

    watch_bcd_field #(.RST_VAL(HOUR_RST)) u_hour (
        .clk      (clk),
        .rst      (rst),
        .inc      (carry_mi),
        .load     (load_ok_c),
        .load_val (ld.hh),
        .min      (FIELD_ZERO),
        .max      (HOUR_MAX),
        .value    (hour),
        .carry    (carry_hh)
    );

    watch_bcd_field #(.RST_VAL(DAY_RST)) u_day (
        .clk      (clk),
        .rst      (rst),
        .inc      (carry_hh),
        .load     (load_ok_c),
        .load_val (ld.dd),
        .min      (FIELD_ONE),
        .max      (day_max_c),
        .value    (day),
        .carry    (carry_dd)
    );

    watch_bcd_field #(.RST_VAL(MONTH_RST)) u_month (
        .clk      (clk),
        .rst      (rst),
        .inc      (carry_dd),
        .load     (load_ok_c),
        .load_val (ld.mm),
        .min      (FIELD_ONE),
        .max      (MONTH_MAX),
        .value    (month),
        .carry    (carry_mm)
    );

    // Year 99 wraps to 00 with nowhere further to carry.
    watch_bcd_field #(.RST_VAL(YEAR_RST)) u_year (
        .clk      (clk),
        .rst      (rst),
        .inc      (carry_mm),
        .load     (load_ok_c),
        .load_val (ld.yy),
        .min      (FIELD_ZERO),
        .max      (YEAR_MAX),
        .value    (year),
        .carry    (unused_carry_yy)
    );

endmodule

// File: tb/tb_watch_counter.sv
// Self-checking bench for watch_counter with CLK_HZ=4.
// Each scenario task pushes expected {fields, tick, load_err} entries to a
// queue while driving stimulus and pops/compares them after each edge.
module tb_watch_counter;

    localparam int unsigned CLK_HZ = 4;
    localparam logic [47:0] RST_T  = 48'h00_01_01_00_00_00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        en_time = 1'b0;
    logic [47:0] bin_time = '0;
    logic [7:0]  year, month, day, hour, minute, second;
    logic        tick, load_err;
    logic [49:0] obs;

    typedef struct {
        string       name;
        logic [49:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    watch_counter #(.CLK_HZ(CLK_HZ)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .en_time  (en_time),
        .bin_time (bin_time),
        .year     (year),
        .month    (month),
        .day      (day),
        .hour     (hour),
        .minute   (minute),
        .second   (second),
        .tick     (tick),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    assign obs = {year, month, day, hour, minute, second, tick, load_err};

    task automatic push(input string n, input logic [47:0] t, input logic tk, input logic le);
        exp_t e;
        e.name = n;
        e.v    = {t, tk, le};
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0; run = 1'b1; en_time = 1'b0; bin_time = '0;
        repeat (2) @(posedge clk);
        #1;
        push("reset_value", RST_T, 1'b0, 1'b0);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.v); end
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            push("reset_tick", {40'h00_01_01_00_00, 8'(k / 4)}, (k % 4 == 0), 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin errors++; $display("FAIL %s[%0d] got %h expected %h", e.name, k, obs, e.v); end
        end
    endtask

    task automatic test_rollover();
        exp_t e;
        logic [47:0] v;
        v = 48'h99_12_31_23_59_59;
        en_time = 1'b1; bin_time = v;
        push("roll_load", v, 1'b0, 1'b0);
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.v); end
        en_time = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            push("roll_run", (k >= 4) ? RST_T : v, (k == 4), 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin errors++; $display("FAIL %s[%0d] got %h expected %h", e.name, k, obs, e.v); end
        end
    endtask

    task automatic test_leap();
        exp_t e;
        logic [47:0] src [3];
        logic [47:0] dst [3];
        src[0] = 48'h24_02_28_23_59_59; dst[0] = 48'h24_02_29_00_00_00;
        src[1] = 48'h23_02_28_23_59_59; dst[1] = 48'h23_03_01_00_00_00;
        src[2] = 48'h24_02_29_23_59_59; dst[2] = 48'h24_03_01_00_00_00;
        for (int i = 0; i < 3; i++) begin
            en_time = 1'b1; bin_time = src[i];
            push("leap_load", src[i], 1'b0, 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin errors++; $display("FAIL %s[%0d] got %h expected %h", e.name, i, obs, e.v); end
            en_time = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                push("leap_run", (k == 4) ? dst[i] : src[i], (k == 4), 1'b0);
                @(posedge clk); #1;
                e = sb.pop_front(); checks++;
                if (obs !== e.v) begin errors++; $display("FAIL %s[%0d.%0d] got %h expected %h", e.name, i, k, obs, e.v); end
            end
        end
    endtask

    task automatic test_invalid();
        exp_t e;
        logic [47:0] base;
        logic [47:0] bad [6];
        logic [47:0] edge_ok;
        base   = 48'h12_06_15_10_20_30;
        bad[0] = 48'h23_02_29_00_00_00;
        bad[1] = 48'h12_06_15_10_20_5A;
        bad[2] = 48'h12_13_15_10_20_30;
        bad[3] = 48'h12_06_00_10_20_30;
        bad[4] = 48'h12_06_15_24_20_30;
        bad[5] = 48'h23_04_31_00_00_00;
        edge_ok = 48'h12_02_29_23_59_59;
        run = 1'b0;
        en_time = 1'b1; bin_time = base;
        push("inv_base", base, 1'b0, 1'b0);
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.v); end
        for (int i = 0; i < 6; i++) begin
            en_time = 1'b1; bin_time = bad[i];
            push("inv_err", base, 1'b0, 1'b1);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin errors++; $display("FAIL %s[%0d] got %h expected %h", e.name, i, obs, e.v); end
            en_time = 1'b0;
            push("inv_clear", base, 1'b0, 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin errors++; $display("FAIL %s[%0d] got %h expected %h", e.name, i, obs, e.v); end
        end
        en_time = 1'b1; bin_time = edge_ok;
        push("inv_leap_ok", edge_ok, 1'b0, 1'b0);
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.v); end
        en_time = 1'b0;
    endtask

    task automatic test_load_tc();
        exp_t e;
        logic [47:0] v, w;
        v = 48'h12_06_15_10_20_30;
        w = 48'h15_07_04_08_00_00;
        run = 1'b1;
        en_time = 1'b1; bin_time = v;
        push("tc_first", v, 1'b0, 1'b0);
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.v); end
        en_time = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            push("tc_count", v, 1'b0, 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin errors++; $display("FAIL %s[%0d] got %h expected %h", e.name, k, obs, e.v); end
        end
        en_time = 1'b1; bin_time = w;
        push("tc_load", w, 1'b0, 1'b0);
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.v); end
        en_time = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            push("tc_after", (k == 4) ? 48'h15_07_04_08_00_01 : w, (k == 4), 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin errors++; $display("FAIL %s[%0d] got %h expected %h", e.name, k, obs, e.v); end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        logic [47:0] cur, nxt, ld;
        cur = 48'h15_07_04_08_00_01;
        nxt = 48'h15_07_04_08_00_02;
        ld  = 48'h20_01_01_00_00_00;
        run = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            run = (k <= 2 || k >= 23);
            push("hold_freeze", (k == 24) ? nxt : cur, (k == 24), 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin errors++; $display("FAIL %s[%0d] got %h expected %h", e.name, k, obs, e.v); end
        end
        for (int k = 1; k <= 2; k++) begin
            push("hold_pre", nxt, 1'b0, 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin errors++; $display("FAIL %s[%0d] got %h expected %h", e.name, k, obs, e.v); end
        end
        run = 1'b0; en_time = 1'b1; bin_time = ld;
        push("hold_load", ld, 1'b0, 1'b0);
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.v); end
        en_time = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            run = (k > 3);
            push("hold_resume", (k == 7) ? 48'h20_01_01_00_00_01 : ld, (k == 7), 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin errors++; $display("FAIL %s[%0d] got %h expected %h", e.name, k, obs, e.v); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [47:0] v;
        v = 48'h21_11_30_12_34_56;
        run = 1'b1; en_time = 1'b1; bin_time = v;
        for (int k = 1; k <= 6; k++) begin
            push("b2b_held", v, 1'b0, 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin errors++; $display("FAIL %s[%0d] got %h expected %h", e.name, k, obs, e.v); end
        end
        en_time = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            push("b2b_release", (k == 4) ? 48'h21_11_30_12_34_57 : v, (k == 4), 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin errors++; $display("FAIL %s[%0d] got %h expected %h", e.name, k, obs, e.v); end
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        run = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            push("mrst_pre", 48'h21_11_30_12_34_57, 1'b0, 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin errors++; $display("FAIL %s[%0d] got %h expected %h", e.name, k, obs, e.v); end
        end
        rst = 1'b0;
        #2;
        push("mrst_async", RST_T, 1'b0, 1'b0);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.v); end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            push("mrst_tick", (k == 4) ? 48'h00_01_01_00_00_01 : RST_T, (k == 4), 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin errors++; $display("FAIL %s[%0d] got %h expected %h", e.name, k, obs, e.v); end
        end
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_leap();
        test_invalid();
        test_load_tc();
        test_hold();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/watch_counter.md
# watch_counter

Real-time clock/calendar core that produces the BCD `year`/`month`/`day`/`hour`/`minute`/`second` fields consumed by the watch setting stage. It sits directly upstream of that stage. It divides `clk` down to a 1 Hz tick, advances a cascaded calendar (2000–2099, leap-year aware), and accepts a full time/date load from the setting stage through `en_time`/`bin_time`. All outputs are registered.

## Interface

Parameters:
- `CLK_HZ`, default 50_000_000: `clk` frequency. The prescaler terminal count is `CLK_HZ-1`. Must be ≥ 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `run`  in  1  count enable. When 0, the prescaler and calendar hold.
- `en_time`  in  1  load strobe from the setting stage, sampled each edge.
- `bin_time`  in  48  load value, packed BCD: [47:40] yy, [39:32] mm, [31:24] dd, [23:16] hh, [15:8] mi, [7:0] ss.
- `year`  out  8  BCD 00–99, representing 2000–2099.
- `month`  out  8  BCD 01–12.
- `day`  out  8  BCD 01 up to the length of the month.
- `hour`  out  8  BCD 00–23.
- `minute`  out  8  BCD 00–59.
- `second`  out  8  BCD 00–59.
- `tick`  out  1  one-cycle pulse, high in the first cycle a new second value is visible.
- `load_err`  out  1  one-cycle pulse when a load is rejected.

## Operation

- **Reset values:** year 8'h00, month 8'h01, day 8'h01, hour/minute/second 8'h00, prescaler 0, tick 0, load_err 0.
- **Prescaler:** when `run`=1 it counts 0..CLK_HZ-1. At the terminal count it wraps to 0 and asserts the advance.
- **Advance cascade:** each field increments in BCD (low nibble 9 → 0 with carry into the high nibble).
  - second 59 → 00, carry into minute.
  - minute 59 → 00, carry into hour.
  - hour 23 → 00, carry into day.
  - day at last-of-month → 01, carry into month.
  - month 12 → 01, carry into year.
  - year 99 → 00, no further carry.
- **Month length:** 31 for months 01/03/05/07/08/10/12; 30 for 04/06/09/11. February is 29 when year mod 4 = 0 (00 counts as leap), otherwise 28.
- **Load validity:** a load is accepted only if all of the following hold:
  - every nibble is ≤ 9;
  - each field is within the ranges above;
  - dd ≤ the month length for the loaded yy/mm.
- **Accepted load:** all six fields take the `bin_time` values and the prescaler clears to 0.
- **Rejected load:** fields and prescaler are unchanged; `load_err`=1 for one cycle.
- **Load priority:** a load (accepted or rejected) takes priority over the advance in the same cycle. On that cycle there is no increment and no tick; for a rejected load, the prescaler also does not advance.
- **`en_time` held high:** the block reloads every cycle, so the prescaler stays at 0 and the fields stay frozen at `bin_time`.
- **`run`=0:** fields and prescaler hold. Loads still work.

## Timing

- **Load latency:** with `en_time`=1 sampled at edge N, the new fields (or the `load_err` pulse) are visible after edge N. That is 1 cycle.
- **Tick timing:** with the prescaler at CLK_HZ-1 and `run`=1 at edge N:
  - the incremented fields and `tick`=1 appear after edge N;
  - `tick` returns to 0 after edge N+1.
- **Tick period:** exactly CLK_HZ cycles between ticks while `run`=1 and no load occurs.
- **After an accepted load:** the first tick occurs CLK_HZ cycles after the load edge.
- **Cascade timing:** the full cascade, including the year wrap, completes within the same single edge. There are no intermediate states visible.
- **Reset:** asserting `rst` at any time (mid-count, mid-cascade, or during a load) immediately forces the reset values. The first tick after release comes CLK_HZ edges after release with `run`=1.

## Structure

- **Shared package `watch_pkg`:**
  - BCD field reset constants (YEAR_RST, MONTH_RST, ...);
  - field maxima (8'h59, 8'h23, 8'h12, 8'h99);
  - a `days_in_month(yy, mm)` function returning BCD 28/29/30/31;
  - a `bcd_valid` function.
  The setting stage reuses these for cursor limits.
- **Sub-module `watch_bcd_field`:** one instance per field. It is an 8-bit BCD register with inputs `inc`, `load`, `load_val`, `min`, `max`, and outputs `value` and `carry` (`carry` = `inc` and `value`==`max`).
- The top level holds the prescaler, the validity check, the load/advance arbitration, and the tick/load_err registers.

## Test plan

Simulate with CLK_HZ=4.

1. **Reset:** assert `rst` and release it with `run`=1. Outputs read 00-01-01 00:00:00. After 4 edges, second=01 with `tick` high for exactly 1 cycle; the next tick comes 4 cycles later.
2. **Full rollover:** load 48'h99_12_31_23_59_59, then run 4 edges. Result is 00-01-01 00:00:00 with one tick.
3. **Leap handling:**
   - 48'h24_02_28_23_59_59 → 24-02-29 00:00:00.
   - 48'h23_02_28_23_59_59 → 23-03-01.
   - 48'h24_02_29_23_59_59 → 24-03-01.
4. **Invalid loads:** each of the following gives `load_err` for 1 cycle with fields unchanged:
   - 48'h23_02_29_00_00_00;
   - ss=8'h5A;
   - mm=8'h13;
   - dd=8'h00;
   - hh=8'h24.
5. **Load on terminal count:** pulse `en_time` on the edge where the prescaler is at 3. The loaded value appears, there is no tick and no increment, and the next tick comes 4 edges later.
6. **Hold and mid-count reset:**
   - `run`=0 for 20 cycles: fields and prescaler are frozen, and a load still applies.
   - Assert `rst` while the prescaler is at 2: outputs are at reset values immediately, independent of `clk`.
